mc_controller: RTL and testbench

Multicycle control unit sequencing the shared RV32I datapath (register file, ALU, data memory, result mux) through Fetch/Decode/Execute/Memory/Writeback steps, one instruction at a time. It drives the same control nets the single-cycle datapath exposes (RegWrite, ALUSrc, MemWrite, ResultSrc, ALUControl), plus the multicycle additions (PCWrite, IRWrite, AdrSrc, two-bit source selects). A `mem_ready` handshake lets a single unified memory take variable latency. Supported subset: lw, sw, R-type ALU, I-type ALU, beq, jal.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_controller_alu_decoder.sv | 32 +++
 rtl/mc_controller.sv | 167 ++++++++++++++++
 tb/tb_mc_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// and the select/control codes driven onto the datapath.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } mc_state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU operation decode from the FSM's ALUOp and the
// instruction's function fields.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can request sub; addi ignores bit 30.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared datapath with a variable-latency memory.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal,
  output mc_state_t  state_dbg
);

  // Memory handshake: the access presented in FETCH, MEMREAD or MEMWRITE
  // completes on the rising edge where mem_ready=1; until then the state and
  // every control output hold unchanged.
  mc_state_t  state, state_next;
  logic       pc_update, branch;
  logic       irwrite_fsm, memwrite_fsm, regwrite_fsm;
  logic       done_next;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      instr_done <= 1'b0;
    end else begin
      state      <= state_next;
      instr_done <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_update    = 1'b0;
    branch       = 1'b0;
    irwrite_fsm  = 1'b0;
    memwrite_fsm = 1'b0;
    regwrite_fsm = 1'b0;
    done_next    = 1'b0;
    alu_op       = ALUOP_ADD;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    case (state)
      FETCH: begin
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        irwrite_fsm = mem_ready;
        pc_update   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BEQ can load it from ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_ITYPE:     state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc    = RES_DATA;
        regwrite_fsm = 1'b1;
        done_next    = 1'b1;
        state_next   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_fsm = 1'b1;
        if (mem_ready) begin
          done_next  = 1'b1;
          state_next = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        regwrite_fsm = 1'b1;
        done_next    = 1'b1;
        state_next   = FETCH;
      end
      JAL: begin
        // Link value OldPC+4 goes to ALUOut while the PC loads the target.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        done_next  = 1'b1;
        state_next = FETCH;
      end
      ILLEGAL: state_next = ILLEGAL;
      default: state_next = FETCH;
    endcase
  end

  // Reset gates the enables combinationally so nothing writes during reset.
  assign PCWrite  = ~rst & (pc_update | (branch & Zero));
  assign IRWrite  = ~rst & irwrite_fsm;
  assign MemWrite = ~rst & memwrite_fsm;
  assign RegWrite = ~rst & regwrite_fsm;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign illegal   = (state == ILLEGAL);
  assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal;
  mc_state_t  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_done_next = 1'b0;
  logic [6:0] ops [6];

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: ALU operation expected in the third step of each instruction.
  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (o == OP_BEQ) return ALU_SUB;
    if (o != OP_RTYPE && o != OP_ITYPE) return ALU_ADD;
    case (f3)
      3'b000:  return (o == OP_RTYPE && f7) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == OP_SW)  return IMM_S;
    if (o == OP_BEQ) return IMM_B;
    if (o == OP_JAL) return IMM_J;
    return IMM_I;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    exp_done_next = 1'b0;
  endtask

  // Runs one supported instruction with the given fetch and memory stall
  // counts; the model lists the named steps and the expected enable totals.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fstall, input int mstall);
    mc_state_t steps[$];
    int  cyc = 0;
    int  n_ir = 0, n_pc = 0, n_rw = 0, n_mw = 0, n_adr = 0;
    int  stall_left;
    bit  waiting;
    bit  is_mem = (o == OP_LW) || (o == OP_SW);
    int  exp_rw  = (o == OP_SW || o == OP_BEQ) ? 0 : 1;
    int  exp_mw  = (o == OP_SW) ? 1 + mstall : 0;
    int  exp_adr = is_mem ? 1 + mstall : 0;
    int  exp_pc  = 1 + ((o == OP_JAL) ? 1 : 0) + ((o == OP_BEQ && z) ? 1 : 0);
    logic [1:0] exp_res = (o == OP_LW) ? RES_DATA : RES_ALUOUT;
    steps.push_back(FETCH);
    steps.push_back(DECODE);
    case (o)
      OP_LW:    begin steps.push_back(MEMADR); steps.push_back(MEMREAD); steps.push_back(MEMWB); end
      OP_SW:    begin steps.push_back(MEMADR); steps.push_back(MEMWRITE); end
      OP_RTYPE: begin steps.push_back(EXECR); steps.push_back(ALUWB); end
      OP_ITYPE: begin steps.push_back(EXECI); steps.push_back(ALUWB); end
      OP_JAL:   begin steps.push_back(JAL); steps.push_back(ALUWB); end
      default:  steps.push_back(BEQ);
    endcase
    foreach (steps[i]) begin
      stall_left = (i == 0) ? fstall : ((steps[i] == MEMREAD || steps[i] == MEMWRITE) ? mstall : 0);
      do begin
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        if (stall_left > 0) mem_ready = 1'b0;
        else if (steps[i] == FETCH || steps[i] == MEMREAD || steps[i] == MEMWRITE) mem_ready = 1'b1;
        else mem_ready = 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (state_dbg !== steps[i]) begin
          n_fail++;
          $display("FAIL state op=%b cyc=%0d: got %0d want %0d", o, cyc, state_dbg, steps[i]);
        end
        n_checks++;
        if (instr_done !== ((cyc == 0) ? exp_done_next : 1'b0)) begin
          n_fail++;
          $display("FAIL instr_done op=%b cyc=%0d: got %b want %b", o, cyc, instr_done, (cyc == 0) ? exp_done_next : 1'b0);
        end
        n_checks++;
        if (ImmSrc !== ref_imm(o) || illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL immsrc/illegal op=%b: got %b/%b want %b/0", o, ImmSrc, illegal, ref_imm(o));
        end
        if (i == 2) begin
          n_checks++;
          if (ALUControl !== ref_alu(o, f3, f7)) begin
            n_fail++;
            $display("FAIL alucontrol op=%b f3=%b f7=%b: got %b want %b", o, f3, f7, ALUControl, ref_alu(o, f3, f7));
          end
        end
        if (RegWrite === 1'b1) begin
          n_checks++;
          if (ResultSrc !== exp_res) begin
            n_fail++;
            $display("FAIL resultsrc op=%b: got %b want %b", o, ResultSrc, exp_res);
          end
        end
        n_ir  += int'(IRWrite === 1'b1);
        n_pc  += int'(PCWrite === 1'b1);
        n_rw  += int'(RegWrite === 1'b1);
        n_mw  += int'(MemWrite === 1'b1);
        n_adr += int'(AdrSrc === 1'b1);
        cyc++;
        waiting = (stall_left > 0);
        stall_left--;
        @(posedge clk);
      end while (waiting);
    end
    n_checks++;
    if (n_ir != 1 || n_pc != exp_pc || n_rw != exp_rw || n_mw != exp_mw || n_adr != exp_adr) begin
      n_fail++;
      $display("FAIL enables op=%b z=%b: ir/pc/rw/mw/adr got %0d/%0d/%0d/%0d/%0d want 1/%0d/%0d/%0d/%0d",
               o, z, n_ir, n_pc, n_rw, n_mw, n_adr, exp_pc, exp_rw, exp_mw, exp_adr);
    end
    exp_done_next = 1'b1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (state_dbg !== FETCH || instr_done !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d done=%b illegal=%b want 0/0/0", state_dbg, instr_done, illegal);
    end
    n_checks++;
    if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_enables: ir=%b pc=%b mw=%b rw=%b want all 0", IRWrite, PCWrite, MemWrite, RegWrite);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (state_dbg !== FETCH) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d want %0d", state_dbg, FETCH);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    exp_done_next = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_LW,    3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(OP_SW,    3'b010, 1'b0, 1'b0, 0, 1);
    run_instr(OP_BEQ,   3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BEQ,   3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_JAL,   3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_ITYPE, 3'b000, 1'b1, 1'b0, 1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (instr_done !== 1'b1 || state_dbg !== FETCH) begin
      n_fail++;
      $display("FAIL last_retire: done=%b state=%0d want 1/%0d", instr_done, state_dbg, FETCH);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_done !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_stall: done=%b ir=%b pc=%b want 0/0/0", instr_done, IRWrite, PCWrite);
    end
    @(posedge clk);
    exp_done_next = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    op = 7'b0000000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (state_dbg !== DECODE || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_decode: state=%0d illegal=%b want %0d/0", state_dbg, illegal, DECODE);
    end
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (state_dbg !== ILLEGAL || illegal !== 1'b1 || instr_done !== 1'b0 ||
          PCWrite !== 1'b0 || IRWrite !== 1'b0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_hold c=%0d: state=%0d illegal=%b done=%b pc=%b ir=%b mw=%b rw=%b",
                 c, state_dbg, illegal, instr_done, PCWrite, IRWrite, MemWrite, RegWrite);
      end
      @(posedge clk);
    end
    do_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (illegal !== 1'b0 || state_dbg !== FETCH) begin
      n_fail++;
      $display("FAIL illegal_clear: illegal=%b state=%0d want 0/%0d", illegal, state_dbg, FETCH);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    op = OP_SW;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== MEMWRITE || MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL memwrite_entry: state=%0d mw=%b want %0d/1", state_dbg, MemWrite, MEMWRITE);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || state_dbg !== FETCH || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_write: mw=%b rw=%b state=%0d illegal=%b want 0/0/%0d/0",
               MemWrite, RegWrite, state_dbg, illegal, FETCH);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    exp_done_next = 1'b0;
    run_instr(OP_RTYPE, 3'b111, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    ops[0] = OP_LW;    ops[1] = OP_SW;  ops[2] = OP_RTYPE;
    ops[3] = OP_ITYPE; ops[4] = OP_JAL; ops[5] = OP_BEQ;
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
